// File: rtl/ysyx_22050612_mem_arbiter_if.sv
// Request/response bundle between the IFU, the LSU, the memory port and the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's view.
interface ysyx_22050612_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_rsp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic                lsu_req_valid;
  logic                lsu_req_ready;
  logic [ADDR_W-1:0]   lsu_addr;
  logic                lsu_wen;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wmask;
  logic                lsu_rsp_valid;
  logic [DATA_W-1:0]   lsu_rdata;

  logic rsp_err;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wen;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_rsp_valid;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata, rsp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata, rsp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_22050612_mem_arbiter.sv
// Round-robin IFU/LSU arbiter for the shared data-memory port, one transaction in flight.
// Grant one cycle after request; requester stalls until mem_req_ready; a hung response times out after TIMEOUT cycles.
module ysyx_22050612_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  ysyx_22050612_mem_arbiter_if.slave bus
);
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ_IFU, REQ_LSU, WAIT_IFU, WAIT_LSU} state_t;

  state_t           state, state_nxt;
  logic             last_lsu, last_lsu_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timed_out;

  assign timed_out = (cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_lsu <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      last_lsu <= last_lsu_nxt;
      cnt      <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    last_lsu_nxt      = last_lsu;
    cnt_nxt           = cnt;
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rdata     = {DATA_W{1'b0}};
    bus.lsu_req_ready = 1'b0;
    bus.lsu_rsp_valid = 1'b0;
    bus.lsu_rdata     = {DATA_W{1'b0}};
    bus.rsp_err       = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_addr      = {ADDR_W{1'b0}};
    bus.mem_wen       = 1'b0;
    bus.mem_wdata     = {DATA_W{1'b0}};
    bus.mem_wmask     = '0;

    case (state)
      IDLE: begin
        // contested grants go to whoever did not win last time
        if (bus.ifu_req_valid && (!bus.lsu_req_valid || last_lsu)) begin
          state_nxt    = REQ_IFU;
          last_lsu_nxt = 1'b0;
        end else if (bus.lsu_req_valid) begin
          state_nxt    = REQ_LSU;
          last_lsu_nxt = 1'b1;
        end
      end
      REQ_IFU: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_addr      = bus.ifu_addr;
        bus.ifu_req_ready = bus.mem_req_ready;
        if (bus.mem_req_ready) begin
          state_nxt = WAIT_IFU;
          cnt_nxt   = '0;
        end
      end
      REQ_LSU: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_addr      = bus.lsu_addr;
        bus.mem_wen       = bus.lsu_wen;
        bus.mem_wdata     = bus.lsu_wdata;
        bus.mem_wmask     = bus.lsu_wmask;
        bus.lsu_req_ready = bus.mem_req_ready;
        if (bus.mem_req_ready) begin
          state_nxt = WAIT_LSU;
          cnt_nxt   = '0;
        end
      end
      WAIT_IFU: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (bus.mem_rsp_valid) begin
          bus.ifu_rsp_valid = 1'b1;
          bus.ifu_rdata     = bus.mem_rdata;
          state_nxt         = IDLE;
        end else if (timed_out) begin
          bus.ifu_rsp_valid = 1'b1;
          bus.rsp_err       = 1'b1;
          state_nxt         = IDLE;
        end
      end
      WAIT_LSU: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (bus.mem_rsp_valid) begin
          bus.lsu_rsp_valid = 1'b1;
          bus.lsu_rdata     = bus.mem_rdata;
          state_nxt         = IDLE;
        end else if (timed_out) begin
          bus.lsu_rsp_valid = 1'b1;
          bus.rsp_err       = 1'b1;
          state_nxt         = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // reset silences everything, including a response landing in the reset cycle
    if (rst) begin
      bus.ifu_req_ready = 1'b0;
      bus.ifu_rsp_valid = 1'b0;
      bus.ifu_rdata     = {DATA_W{1'b0}};
      bus.lsu_req_ready = 1'b0;
      bus.lsu_rsp_valid = 1'b0;
      bus.lsu_rdata     = {DATA_W{1'b0}};
      bus.rsp_err       = 1'b0;
      bus.mem_req_valid = 1'b0;
      bus.mem_addr      = {ADDR_W{1'b0}};
      bus.mem_wen       = 1'b0;
      bus.mem_wdata     = {DATA_W{1'b0}};
      bus.mem_wmask     = '0;
    end
  end
endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Directed vector bench for the IFU/LSU memory arbiter: default-TIMEOUT instance plus a TIMEOUT=4 instance.
module tb_ysyx_22050612_mem_arbiter;
  typedef struct packed {
    logic        rst;
    logic        ifu_v;
    logic [63:0] ifu_addr;
    logic        lsu_v;
    logic [63:0] lsu_addr;
    logic        lsu_wen;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        mem_rdy;
    logic        mem_rsp;
    logic [63:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        ifu_req_ready;
    logic        ifu_rsp_valid;
    logic [63:0] ifu_rdata;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;
    logic [63:0] lsu_rdata;
    logic        rsp_err;
    logic        mem_req_valid;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  localparam logic [63:0] IA = 64'h0000_0000_8000_0000;
  localparam logic [63:0] LA = 64'h0000_0000_8000_1000;
  localparam logic [63:0] WD = 64'h1122_3344_5566_7788;
  localparam logic [7:0]  WM = 8'hF0;
  localparam logic [63:0] RD = 64'h0000_0000_0010_0073;
  localparam logic [63:0] DA = 64'h0000_0000_0000_DEAD;
  localparam logic [63:0] CD = 64'h0000_0000_00C0_FFEE;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ysyx_22050612_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus0 ();
  ysyx_22050612_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus1 ();

  ysyx_22050612_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(255)) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0)
  );
  ysyx_22050612_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1)
  );

  function automatic in_t mk_in(input logic r, input logic iv, input logic [63:0] ia,
                                input logic lv, input logic [63:0] la, input logic lw,
                                input logic [63:0] lwd, input logic [7:0] lm,
                                input logic mr, input logic mv, input logic [63:0] md);
    in_t v;
    v.rst = r; v.ifu_v = iv; v.ifu_addr = ia; v.lsu_v = lv; v.lsu_addr = la;
    v.lsu_wen = lw; v.lsu_wdata = lwd; v.lsu_wmask = lm;
    v.mem_rdy = mr; v.mem_rsp = mv; v.mem_rdata = md;
    return v;
  endfunction

  function automatic out_t mk_out(input logic irr, input logic irv, input logic [63:0] ird,
                                  input logic lrr, input logic lrv, input logic [63:0] lrd,
                                  input logic err, input logic mrv, input logic [63:0] ma,
                                  input logic mw, input logic [63:0] mwd, input logic [7:0] mwm);
    out_t o;
    o.ifu_req_ready = irr; o.ifu_rsp_valid = irv; o.ifu_rdata = ird;
    o.lsu_req_ready = lrr; o.lsu_rsp_valid = lrv; o.lsu_rdata = lrd;
    o.rsp_err = err; o.mem_req_valid = mrv; o.mem_addr = ma;
    o.mem_wen = mw; o.mem_wdata = mwd; o.mem_wmask = mwm;
    return o;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    vecs.push_back(v);
  endtask

  task automatic drive0(input in_t v);
    rst0 = v.rst;
    bus0.ifu_req_valid = v.ifu_v;  bus0.ifu_addr = v.ifu_addr;
    bus0.lsu_req_valid = v.lsu_v;  bus0.lsu_addr = v.lsu_addr;
    bus0.lsu_wen = v.lsu_wen;      bus0.lsu_wdata = v.lsu_wdata; bus0.lsu_wmask = v.lsu_wmask;
    bus0.mem_req_ready = v.mem_rdy; bus0.mem_rsp_valid = v.mem_rsp; bus0.mem_rdata = v.mem_rdata;
  endtask

  task automatic drive1(input in_t v);
    rst1 = v.rst;
    bus1.ifu_req_valid = v.ifu_v;  bus1.ifu_addr = v.ifu_addr;
    bus1.lsu_req_valid = v.lsu_v;  bus1.lsu_addr = v.lsu_addr;
    bus1.lsu_wen = v.lsu_wen;      bus1.lsu_wdata = v.lsu_wdata; bus1.lsu_wmask = v.lsu_wmask;
    bus1.mem_req_ready = v.mem_rdy; bus1.mem_rsp_valid = v.mem_rsp; bus1.mem_rdata = v.mem_rdata;
  endtask

  function automatic out_t sample0();
    return mk_out(bus0.ifu_req_ready, bus0.ifu_rsp_valid, bus0.ifu_rdata,
                  bus0.lsu_req_ready, bus0.lsu_rsp_valid, bus0.lsu_rdata,
                  bus0.rsp_err, bus0.mem_req_valid, bus0.mem_addr,
                  bus0.mem_wen, bus0.mem_wdata, bus0.mem_wmask);
  endfunction

  function automatic out_t sample1();
    return mk_out(bus1.ifu_req_ready, bus1.ifu_rsp_valid, bus1.ifu_rdata,
                  bus1.lsu_req_ready, bus1.lsu_rsp_valid, bus1.lsu_rdata,
                  bus1.rsp_err, bus1.mem_req_valid, bus1.mem_addr,
                  bus1.mem_wen, bus1.mem_wdata, bus1.mem_wmask);
  endfunction

  // inputs change just after the edge, outputs are read on the falling edge
  task automatic step0(input in_t v);
    @(posedge clk); #1; drive0(v); @(negedge clk);
  endtask

  task automatic step1(input in_t v);
    @(posedge clk); #1; drive1(v); @(negedge clk);
  endtask

  task automatic check_out(input string name, input out_t act, input out_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  initial begin
    out_t zo, req_i, req_l, rsp_i, rsp_l, o;
    in_t  idle, cont, lsu_w;
    int   n;
    logic any_mrv;

    zo    = '0;
    idle  = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive0(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive1(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // reset, IFU-only read, stray response in IDLE
    add(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), zo);
    add(mk_in(0, 1, IA, 0, 0, 0, 0, 0, 1, 0, 0), zo);
    add(mk_in(0, 1, IA, 0, 0, 0, 0, 0, 1, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 1, IA, 0, 0, 0));
    add(idle, zo);
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RD), mk_out(0, 1, RD, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RD), zo);
    // LSU write with ready held off for two REQ cycles; a response during REQ is ignored
    lsu_w = mk_in(0, 0, 0, 1, LA, 1, WD, WM, 0, 0, 0);
    add(lsu_w, zo);
    add(lsu_w, mk_out(0, 0, 0, 0, 0, 0, 0, 1, LA, 1, WD, WM));
    add(mk_in(0, 0, 0, 1, LA, 1, WD, WM, 0, 1, RD), mk_out(0, 0, 0, 0, 0, 0, 0, 1, LA, 1, WD, WM));
    add(mk_in(0, 0, 0, 1, LA, 1, WD, WM, 1, 0, 0), mk_out(0, 0, 0, 1, 0, 0, 0, 1, LA, 1, WD, WM));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DA), mk_out(0, 0, 0, 0, 1, DA, 0, 0, 0, 0, 0, 0));
    // both requesting continuously from reset: LSU, IFU, LSU, IFU
    cont  = mk_in(0, 1, IA, 1, LA, 0, 0, 0, 1, 1, CD);
    req_i = mk_out(1, 0, 0, 0, 0, 0, 0, 1, IA, 0, 0, 0);
    req_l = mk_out(0, 0, 0, 1, 0, 0, 0, 1, LA, 0, 0, 0);
    rsp_i = mk_out(0, 1, CD, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rsp_l = mk_out(0, 0, 0, 0, 1, CD, 0, 0, 0, 0, 0, 0);
    add(mk_in(1, 1, IA, 1, LA, 0, 0, 0, 1, 1, CD), zo);
    add(cont, zo); add(cont, req_l); add(cont, rsp_l);
    add(cont, zo); add(cont, req_i); add(cont, rsp_i);
    add(cont, zo); add(cont, req_l); add(cont, rsp_l);
    add(cont, zo); add(cont, req_i); add(cont, rsp_i);

    foreach (vecs[k]) begin
      step0(vecs[k].i);
      check_out($sformatf("vec%0d", k), sample0(), vecs[k].o);
    end

    // watchdog: IFU accepted, memory never answers
    step0(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step0(mk_in(0, 1, IA, 0, 0, 0, 0, 0, 1, 0, 0));
    step0(mk_in(0, 1, IA, 0, 0, 0, 0, 0, 1, 0, 0));
    check_out("to_req", sample0(), req_i);
    n = -1;
    any_mrv = 1'b0;
    o = zo;
    for (int k = 0; k < 300 && n < 0; k++) begin
      step0(idle);
      if (bus0.mem_req_valid) any_mrv = 1'b1;
      if (bus0.ifu_rsp_valid) begin
        n = k;
        o = sample0();
      end
    end
    check_val("to_cycles", 64'(n), 64'd255);
    check_out("to_pulse", o, mk_out(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    check_val("to_no_mrv", 64'(any_mrv), 64'd0);
    step0(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DA));
    check_out("to_late_rsp", sample0(), zo);

    // reset while in WAIT_LSU, response arriving during and after reset
    step0(mk_in(0, 0, 0, 1, LA, 0, 0, 0, 1, 0, 0));
    step0(mk_in(0, 0, 0, 1, LA, 0, 0, 0, 1, 0, 0));
    check_out("rw_req", sample0(), req_l);
    step0(idle);
    check_out("rw_wait", sample0(), zo);
    step0(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, DA));
    check_out("rw_in_rst", sample0(), zo);
    step0(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DA));
    check_out("rw_after_rst", sample0(), zo);
    step0(mk_in(0, 1, IA, 0, 0, 0, 0, 0, 0, 0, 0));
    step0(mk_in(0, 1, IA, 0, 0, 0, 0, 0, 0, 0, 0));
    check_out("rw_idle_regrant", sample0(), mk_out(0, 0, 0, 0, 0, 0, 0, 1, IA, 0, 0, 0));

    // TIMEOUT=4: response coinciding with the timeout cycle wins
    step1(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step1(mk_in(0, 0, 0, 1, LA, 0, 0, 0, 1, 0, 0));
    step1(mk_in(0, 0, 0, 1, LA, 0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 4; k++) step1(idle);
    check_out("t4_wait3", sample1(), zo);
    step1(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DA));
    check_out("t4_collide", sample1(), mk_out(0, 0, 0, 0, 1, DA, 0, 0, 0, 0, 0, 0));
    // and without a response it fires on the fifth WAIT cycle
    step1(mk_in(0, 0, 0, 1, LA, 0, 0, 0, 1, 0, 0));
    step1(mk_in(0, 0, 0, 1, LA, 0, 0, 0, 1, 0, 0));
    n = -1;
    o = zo;
    for (int k = 0; k < 20 && n < 0; k++) begin
      step1(idle);
      if (bus1.lsu_rsp_valid) begin
        n = k;
        o = sample1();
      end
    end
    check_val("t4_to_cycles", 64'(n), 64'd4);
    check_out("t4_to_pulse", o, mk_out(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_22050612_mem_arbiter.md
# ysyx_22050612_mem_arbiter

Two-requester arbiter that shares the single data-memory port between the instruction fetch unit (IFU) and the load/store path of the execute unit (LSU). It replaces the direct combinational `pmem_read` access inside the EXU. Each requester gets a valid/ready request channel and a response pulse. One transaction is outstanding at a time, contested grants alternate round-robin, and a watchdog terminates hung responses.

## Interface
Parameters:
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width (wmask width = DATA_W/8)
- `TIMEOUT`, 255, max cycles waiting for `mem_rsp_valid` before error; counter width = $clog2(TIMEOUT+1)

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  reset; synchronous, active-high
- `ifu_req_valid`  in  1  IFU read request
- `ifu_req_ready`  out  1  IFU request accepted this cycle
- `ifu_addr`  in  ADDR_W  IFU read address
- `ifu_rsp_valid`  out  1  one-cycle IFU response pulse
- `ifu_rdata`  out  DATA_W  IFU read data
- `lsu_req_valid`  in  1  LSU request
- `lsu_req_ready`  out  1  LSU request accepted this cycle
- `lsu_addr`  in  ADDR_W  LSU address
- `lsu_wen`  in  1  1 = write, 0 = read
- `lsu_wdata`  in  DATA_W  write data
- `lsu_wmask`  in  DATA_W/8  byte write mask
- `lsu_rsp_valid`  out  1  one-cycle LSU response pulse (reads and writes)
- `lsu_rdata`  out  DATA_W  LSU read data
- `rsp_err`  out  1  qualifies either rsp_valid pulse: 1 = timeout
- `mem_req_valid`  out  1  request to memory
- `mem_req_ready`  in  1  memory accepts request
- `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wmask`  out  ADDR_W/1/DATA_W/DATA_W/8  forwarded from owner
- `mem_rsp_valid`  in  1  memory response
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- States: IDLE, REQ_IFU, REQ_LSU, WAIT_IFU, WAIT_LSU. Register `last` holds the last granted requester.
- IDLE, arbitration:
  - Only one valid → REQ of that requester.
  - Both valid → grant the requester not equal to `last`.
  - Neither valid → stay in IDLE.
  - Entering REQ_x sets `last` = x.
- REQ_x:
  - `mem_req_valid` = 1.
  - `mem_*` fields are muxed from requester x. For the IFU, `mem_wen`, `mem_wdata` and `mem_wmask` are 0.
  - `x_req_ready` = `mem_req_ready`.
  - On `mem_req_ready` → WAIT_x and clear the timeout counter.
  - A requester must hold valid and fields stable until ready. Dropping valid before the handshake is a protocol violation; the arbiter still completes the transaction with the held-by-mux values.
- WAIT_x:
  - `mem_req_valid` = 0. The counter increments each cycle.
  - On `mem_rsp_valid`: `x_rsp_valid` = 1 and `x_rdata` = `mem_rdata` (combinational pass-through), `rsp_err` = 0, then → IDLE.
  - Counter reaches TIMEOUT without a response: `x_rsp_valid` = 1, `x_rdata` = 0, `rsp_err` = 1, then → IDLE.
- `mem_rsp_valid` in IDLE or REQ_* is ignored. This drops stray or late responses, including one arriving after a timeout.
- The non-owner's ready and rsp_valid are always 0. `ifu_rdata` and `lsu_rdata` are 0 when their rsp_valid is 0.

## Timing
- Reset: state = IDLE, `last` = IFU (so the first contested grant goes to the LSU), counter = 0.
- All outputs are 0 during and immediately after reset: `mem_req_valid`, both readys, both rsp_valids, `rsp_err`, `mem_*` fields, both rdatas.
- Reset mid-transaction aborts it. No response is issued to the owner, and the next state is IDLE.
- Grant latency: a request sampled in IDLE at cycle N gives `mem_req_valid` = 1 in cycle N+1.
- Minimum transaction is 3 cycles: IDLE, REQ (ready same cycle), WAIT (response same cycle). Back-to-back transactions are separated by one IDLE cycle.
- `mem_req_valid` and `mem_*` fields depend only on state and the owner's inputs. They are never combinational on `mem_req_ready`.
- Simultaneous response and new requests in WAIT: the response completes, and arbitration happens in the following IDLE cycle using the updated `last`.
- Timeout fires in the cycle the counter equals TIMEOUT. With the default, that is the 256th WAIT cycle. A real response in that same cycle wins: `rsp_err` = 0.

## Test plan
- IFU only: addr 0x80000000; mem ready at once, rsp after 2 cycles with rdata 0x00100073 → `ifu_rsp_valid` pulse with that data, `rsp_err` = 0, 4 cycles total.
- LSU write: addr 0x80001000, wdata 0x11223344_55667788, wmask 0xF0; ready delayed 3 cycles → `mem_*` stable through REQ, `lsu_req_ready` only on the 3rd cycle, then one `lsu_rsp_valid` pulse.
- Contention: both request continuously for 4 transactions starting from reset → grant order LSU, IFU, LSU, IFU.
- Timeout: IFU request accepted, no response → `ifu_rsp_valid` = 1, `rsp_err` = 1, rdata 0 exactly 255 cycles after entering WAIT. A later `mem_rsp_valid` produces no output.
- Reset in WAIT_LSU, then response arrives → no `lsu_rsp_valid`, state IDLE, all outputs 0.
- Response and timeout in the same cycle (TIMEOUT = 4 override) → `rsp_err` = 0, data forwarded.
